// File: rtl/password_readback.sv
// Purpose: replays three captured password digits on DIGIT/LEDS, one digit per HOLD_CYCLES window.
// Latency: first digit appears the cycle after START is accepted; DONE pulses on the first IDLE cycle.
// Backpressure: none; START is ignored while BUSY, ABORT cancels. Optional macro READBACK_GAP_EN adds blank gaps.
module password_readback #(
  parameter int HOLD_CYCLES = 100,
  parameter int GAP_CYCLES  = 20
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       ABORT,
  input  logic [2:0] P1,
  input  logic [2:0] P2,
  input  logic [2:0] P3,
  output logic [2:0] DIGIT,
  output logic       DIGIT_VALID,
  output logic [1:0] IDX,
  output logic [2:0] LEDS,
  output logic       BUSY,
  output logic       DONE
);

`ifdef READBACK_GAP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHOW = 2'd1, GAP = 2'd2} state_t;
  localparam logic [23:0] GAP_LAST = 24'(GAP_CYCLES - 1);
  logic [23:0] gap_cnt, gap_cnt_nxt;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHOW = 2'd1} state_t;
`endif

  localparam logic [23:0] HOLD_LAST = 24'(HOLD_CYCLES - 1);

  state_t      state, state_nxt;
  logic [23:0] hold_cnt, hold_cnt_nxt;
  logic [1:0]  idx_q, idx_nxt;
  logic        done_q, done_nxt;
  logic        capture;
  logic [2:0]  dig1, dig2, dig3;

  // State, index, counters and the DONE pulse register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      hold_cnt <= '0;
      idx_q    <= 2'd0;
      done_q   <= 1'b0;
`ifdef READBACK_GAP_EN
      gap_cnt  <= '0;
`endif
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
      idx_q    <= idx_nxt;
      done_q   <= done_nxt;
`ifdef READBACK_GAP_EN
      gap_cnt  <= gap_cnt_nxt;
`endif
    end
  end

  // Snapshot of the password taken when playback starts; later input changes are ignored
  always_ff @(posedge CLK) begin
    if (RST) begin
      dig1 <= 3'd0;
      dig2 <= 3'd0;
      dig3 <= 3'd0;
    end else if (capture) begin
      dig1 <= P1;
      dig2 <= P2;
      dig3 <= P3;
    end
  end

  // Next-state logic: ABORT beats hold/gap expiry; START only counts in IDLE
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    idx_nxt      = idx_q;
    done_nxt     = 1'b0;
    capture      = 1'b0;
`ifdef READBACK_GAP_EN
    gap_cnt_nxt  = gap_cnt;
`endif
    case (state)
      IDLE: begin
        if (START) begin
          capture      = 1'b1;
          state_nxt    = SHOW;
          idx_nxt      = 2'd1;
          hold_cnt_nxt = '0;
        end
      end
      SHOW: begin
        if (ABORT) begin
          state_nxt    = IDLE;
          idx_nxt      = 2'd0;
          hold_cnt_nxt = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          hold_cnt_nxt = '0;
          if (idx_q == 2'd3) begin
            state_nxt = IDLE;
            idx_nxt   = 2'd0;
            done_nxt  = 1'b1;
          end else begin
`ifdef READBACK_GAP_EN
            // IDX keeps the digit just shown until the gap ends
            state_nxt   = GAP;
            gap_cnt_nxt = '0;
`else
            idx_nxt     = idx_q + 2'd1;
`endif
          end
        end else begin
          hold_cnt_nxt = hold_cnt + 24'd1;
        end
      end
`ifdef READBACK_GAP_EN
      GAP: begin
        if (ABORT) begin
          state_nxt   = IDLE;
          idx_nxt     = 2'd0;
          gap_cnt_nxt = '0;
        end else if (gap_cnt == GAP_LAST) begin
          gap_cnt_nxt  = '0;
          hold_cnt_nxt = '0;
          state_nxt    = SHOW;
          idx_nxt      = idx_q + 2'd1;
        end else begin
          gap_cnt_nxt = gap_cnt + 24'd1;
        end
      end
`endif
      default: begin
        state_nxt    = IDLE;
        idx_nxt      = 2'd0;
        hold_cnt_nxt = '0;
      end
    endcase
  end

  // Output decode: a digit is only driven while in SHOW
  always_comb begin
    DIGIT       = 3'd0;
    DIGIT_VALID = 1'b0;
    LEDS        = 3'd0;
    if (state == SHOW) begin
      DIGIT_VALID = 1'b1;
      case (idx_q)
        2'd1: begin DIGIT = dig1; LEDS = 3'b001; end
        2'd2: begin DIGIT = dig2; LEDS = 3'b010; end
        2'd3: begin DIGIT = dig3; LEDS = 3'b100; end
        default: begin DIGIT = 3'd0; LEDS = 3'b000; end
      endcase
    end
  end

  assign IDX  = idx_q;
  assign BUSY = (state != IDLE);
  assign DONE = done_q;

endmodule

// File: doc/password_readback.md
PASSWORD_READBACK -- requirements
Module: password_readback

Interface
REQ-001 Parameter HOLD_CYCLES, default 100, number of clock cycles each password digit is presented; legal range 1 to 2^24-1.
REQ-002 Parameter GAP_CYCLES, default 20, number of blank cycles between digits; used only when READBACK_GAP_EN is defined; legal range 1 to 2^24-1.
REQ-003 CLK  input  1  single system clock; all state updates on its rising edge.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 START  input  1  request playback; sampled only in IDLE.
REQ-006 ABORT  input  1  cancel playback in progress.
REQ-007 P1, P2, P3  input  3 each  stored password digits 1..3, driven by the password register set.
REQ-008 DIGIT  output  3  digit currently presented.
REQ-009 DIGIT_VALID  output  1  high while DIGIT carries a password digit.
REQ-010 IDX  output  2  index of the digit presented: 1, 2 or 3; 0 when idle.
REQ-011 LEDS  output  3  one-hot digit indicator: bit 0 for digit 1, bit 1 for digit 2, bit 2 for digit 3; 000 when no digit is shown.
REQ-012 BUSY  output  1  high from the cycle after START is accepted until playback ends.
REQ-013 DONE  output  1  one-cycle pulse on normal completion.

Function
REQ-014 FSM states SHALL be IDLE, SHOW and GAP; GAP exists only when READBACK_GAP_EN is defined.
REQ-015 IDLE with START=1 SHALL capture P1..P3 into internal registers and enter SHOW with IDX=1 and the hold counter at 0.
REQ-016 Playback SHALL use only the captured values; changes on P1..P3 during playback have no effect.
REQ-017 SHOW SHALL drive DIGIT to the captured digit for IDX, DIGIT_VALID=1 and LEDS one-hot, for exactly HOLD_CYCLES cycles.
REQ-018 At the end of the hold for IDX 1 or 2, the FSM SHALL advance to IDX+1; it enters GAP first when the macro is defined, otherwise it goes directly to SHOW.
REQ-019 At the end of the hold for IDX 3, the FSM SHALL enter IDLE and assert DONE for exactly that first IDLE cycle.
REQ-020 Outside SHOW, the outputs SHALL be: DIGIT=000, DIGIT_VALID=0, LEDS=000.
REQ-021 In IDLE, IDX SHALL be 0 and BUSY SHALL be 0.
REQ-022 BUSY SHALL be 1 in SHOW and GAP.
REQ-023 START while BUSY SHALL be ignored.
REQ-024 A START pulse coincident with a DONE cycle SHALL be accepted, since the FSM is in IDLE on that cycle.
REQ-025 ABORT=1 in SHOW or GAP SHALL return the FSM to IDLE on the next cycle with DONE=0.
REQ-026 ABORT has priority over START and over hold or gap expiry.
REQ-027 ABORT in IDLE SHALL be ignored, and START SHALL still be accepted on the same cycle.
REQ-028 The hold counter and the gap counter SHALL be 24 bits wide; they count from 0 to N-1 and then clear, with no wrap-around beyond that.
REQ-029 HOLD_CYCLES=1 SHALL give one cycle per digit with no dead cycles between consecutive SHOW states.

Reset
REQ-030 RST=1 SHALL force the following on the next edge: IDLE, all counters 0, captured digits 000, DIGIT=000, DIGIT_VALID=0, IDX=0, LEDS=000, BUSY=0, DONE=0.
REQ-031 RST SHALL take priority over START, ABORT and all internal events.
REQ-032 RST asserted mid-playback SHALL abort the playback without generating a DONE pulse.

Configuration
REQ-033 Macro READBACK_GAP_EN: when defined, GAP_CYCLES blank cycles SHALL be inserted after digits 1 and 2, with none after digit 3.
REQ-034 In GAP, IDX SHALL hold the value of the digit just shown, and BUSY SHALL stay 1.
REQ-035 When READBACK_GAP_EN is undefined, the GAP state and its counter SHALL be absent, and the GAP_CYCLES parameter SHALL be ignored.

Verification
REQ-036 No macro, HOLD=3, P=5/2/7, START at cycle 0 -> DIGIT 5 in cycles 1-3, 2 in cycles 4-6, 7 in cycles 7-9; LEDS 001/010/100 for the same windows; DONE=1 only in cycle 10; BUSY high in cycles 1-9.
REQ-037 Macro defined, HOLD=3, GAP=2, same stimulus -> digits in cycles 1-3, 6-8 and 11-13; DIGIT_VALID=0 in cycles 4-5 and 9-10; DONE at cycle 14.
REQ-038 No macro, HOLD=3, P1 changed to 0 at cycle 2 and START pulsed again at cycle 5 -> output sequence still 5/2/7 with the same cycle windows; the second START is ignored.
REQ-039 ABORT at cycle 5 (during digit 2) -> cycle 6 is IDLE with all outputs 0, and DONE never asserts.
REQ-040 RST at cycle 8 with START also high -> cycle 9 shows the reset values from REQ-030, with no DONE and no new playback.
REQ-041 HOLD=1, START repeated on the DONE cycle -> back-to-back playbacks, each showing 3 consecutive digit cycles, with BUSY low only during the DONE cycle.
